// File: rtl/dmem_lsu_if.sv
// Request/response and debug-init bundle between the core's MEM stage and dmem_lsu.
//   master: drives req_* and dbg_*, receives req_ready and rsp_*.
//   slave : the load-store unit.
// Signals:
//   req_valid/req_ready  request handshake
//   req_we, req_funct3   store flag and size/extension code (instr[14:12])
//   req_addr, req_wdata  byte address and store data
//   rsp_valid            single-cycle response pulse
//   rsp_rdata            extended load data (0 for stores/faults)
//   rsp_fault            access not performed
//   dbg_en, dbg_addr     debug init write enable and first word index
//   dbg_wdata            INIT_LANES packed words, lane i -> word dbg_addr+i
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned INIT_LANES = 2
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct3;
  logic [ADDR_W-1:0]       req_addr;
  logic [31:0]             req_wdata;
  logic                    rsp_valid;
  logic [31:0]             rsp_rdata;
  logic                    rsp_fault;
  logic                    dbg_en;
  logic [ADDR_W-3:0]       dbg_addr;
  logic [32*INIT_LANES-1:0] dbg_wdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output dbg_en, dbg_addr, dbg_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  dbg_en, dbg_addr, dbg_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lsu.sv
// Pipelined RV32 data memory / load-store unit for the MEM stage.
// Word storage with byte-lane stores and sign/zero-extended loads. Misaligned accesses are
// either split into two word accesses (MISALIGN_SPLIT=1) or faulted. A debug port writes
// INIT_LANES words per cycle and takes priority over core requests.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_lsu_if slave: req_* handshake, rsp_* response, dbg_* init port
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned INIT_LANES     = 2,
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_lsu_if.slave   bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned WIDX_W = ADDR_W - 2;
  // One extra bit so DEPTH_WORDS itself is representable for the range compare.
  localparam logic [WIDX_W:0] DEPTH_LIM = (WIDX_W + 1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StSplit, StResp} state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e            state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [31:0]       hold_q, hold_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d;
  logic [31:0]       whi_q, whi_d;
  logic [3:0]        behi_q, behi_d;

  logic [1:0]        off;
  logic [WIDX_W-1:0] widx;
  logic [IDX_W-1:0]  idx0;
  logic [IDX_W-1:0]  dbg_idx;
  logic              is_byte, is_half;
  logic              misaligned, oor, fault_now, accept;
  logic [3:0]        size_mask;
  logic [7:0]        be64;
  logic [63:0]       wdata64;
  logic [31:0]       rd0, rd1;
  logic [63:0]       pair;
  logic              unused_dbg;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   r = f3[2] ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request decode
  assign off        = bus.req_addr[1:0];
  assign widx       = bus.req_addr[ADDR_W-1:2];
  assign idx0       = widx[IDX_W-1:0];
  assign dbg_idx    = bus.dbg_addr[IDX_W-1:0];
  assign unused_dbg = ^bus.dbg_addr;
  assign is_byte    = (bus.req_funct3[1:0] == 2'b00);
  assign is_half    = (bus.req_funct3[1:0] == 2'b01);
  assign size_mask  = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
  // Lanes spill into the upper nibble / upper word only for misaligned accesses.
  assign be64       = {4'b0000, size_mask} << off;
  assign wdata64    = {32'b0, bus.req_wdata} << {off, 3'b000};
  assign oor        = ({1'b0, widx} >= DEPTH_LIM);
  assign misaligned = (is_half && off == 2'd3) || (!is_byte && !is_half && off != 2'd0);
  assign fault_now  = oor || (misaligned && MISALIGN_SPLIT == 0);
  assign accept     = bus.req_valid && bus.req_ready;

  assign rd0 = mem[idx0];
  assign rd1 = mem[idx1_q];

  assign bus.req_ready = !bus.dbg_en && (state_q != StSplit);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fault = fault_q;

  // Storage: no reset on contents.
  always_ff @(posedge clk) begin
    if (bus.dbg_en) begin
      for (int l = 0; l < int'(INIT_LANES); l++) begin
        mem[dbg_idx + IDX_W'(l)] <= bus.dbg_wdata[32*l +: 32];
      end
    end else begin
      if (accept && bus.req_we && !fault_now) begin
        for (int b = 0; b < 4; b++) begin
          if (be64[b]) mem[idx0][8*b +: 8] <= wdata64[8*b +: 8];
        end
      end
      if (state_q == StSplit && we_q) begin
        for (int b = 0; b < 4; b++) begin
          if (behi_q[b]) mem[idx1_q][8*b +: 8] <= whi_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rdata_q <= '0;
      fault_q <= 1'b0;
      hold_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      idx1_q  <= '0;
      whi_q   <= '0;
      behi_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      hold_q  <= hold_d;
      off_q   <= off_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      idx1_q  <= idx1_d;
      whi_q   <= whi_d;
      behi_q  <= behi_d;
    end
  end

  // rdata_d/fault_d default to 0 so the response registers are 0 outside StResp.
  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    fault_d = 1'b0;
    hold_d  = hold_q;
    off_d   = off_q;
    we_d    = we_q;
    f3_d    = f3_q;
    idx1_d  = idx1_q;
    whi_d   = whi_q;
    behi_d  = behi_q;
    pair    = '0;
    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (accept) begin
          if (fault_now) begin
            state_d = StResp;
            fault_d = 1'b1;
          end else if (misaligned) begin
            state_d = StSplit;
            off_d   = off;
            we_d    = bus.req_we;
            f3_d    = bus.req_funct3;
            idx1_d  = idx0 + IDX_W'(1);
            whi_d   = wdata64[63:32];
            behi_d  = be64[7:4];
            if (!bus.req_we) hold_d = rd0;
          end else begin
            state_d = StResp;
            if (!bus.req_we) rdata_d = extend(rd0 >> {off, 3'b000}, bus.req_funct3);
          end
        end
      end
      StSplit: begin
        state_d = StResp;
        if (!we_q) begin
          pair    = {rd1, hold_q} >> {off_q, 3'b000};
          rdata_d = extend(pair[31:0], f3_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned LANES = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus; sel routes req_valid to the split (0) or fault (1) instance.
  logic              sel;
  logic              req_valid, req_we;
  logic [2:0]        req_funct3;
  logic [AW-1:0]     req_addr;
  logic [31:0]       req_wdata;
  logic              dbg_en;
  logic [AW-3:0]     dbg_addr;
  logic [32*LANES-1:0] dbg_wdata;

  dmem_lsu_if #(.ADDR_W(AW), .INIT_LANES(LANES)) bus_s ();
  dmem_lsu_if #(.ADDR_W(AW), .INIT_LANES(LANES)) bus_f ();

  assign bus_s.req_valid  = req_valid && !sel;
  assign bus_f.req_valid  = req_valid && sel;
  assign bus_s.req_we     = req_we;
  assign bus_f.req_we     = req_we;
  assign bus_s.req_funct3 = req_funct3;
  assign bus_f.req_funct3 = req_funct3;
  assign bus_s.req_addr   = req_addr;
  assign bus_f.req_addr   = req_addr;
  assign bus_s.req_wdata  = req_wdata;
  assign bus_f.req_wdata  = req_wdata;
  assign bus_s.dbg_en     = dbg_en;
  assign bus_f.dbg_en     = dbg_en;
  assign bus_s.dbg_addr   = dbg_addr;
  assign bus_f.dbg_addr   = dbg_addr;
  assign bus_s.dbg_wdata  = dbg_wdata;
  assign bus_f.dbg_wdata  = dbg_wdata;

  wire        req_ready = sel ? bus_f.req_ready : bus_s.req_ready;
  wire        rsp_valid = sel ? bus_f.rsp_valid : bus_s.rsp_valid;
  wire [31:0] rsp_rdata = sel ? bus_f.rsp_rdata : bus_s.rsp_rdata;
  wire        rsp_fault = sel ? bus_f.rsp_fault : bus_s.rsp_fault;

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .INIT_LANES(LANES), .MISALIGN_SPLIT(1)) u_split (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .INIT_LANES(LANES), .MISALIGN_SPLIT(0)) u_fault (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h03020100 + 32'h04040404 * 32'(i);
  endfunction

  typedef struct {
    bit          sel;
    bit          we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          flt;
    bit          spl;
  } vec_t;

  vec_t vecs [26];

  // Called at a negedge; leaves the bench at the next negedge after the response.
  task automatic do_req(input string name, input bit s, input bit we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_flt, input bit exp_spl);
    int n;
    sel = s; req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (exp_spl) begin
      chk({name, "_n1_valid"}, 32'(rsp_valid), 32'd0);
      chk({name, "_n1_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_rdata"}, rsp_rdata, exp_rd);
    chk({name, "_fault"}, 32'(rsp_fault), 32'(exp_flt));
    @(negedge clk);
  endtask

  initial begin
    int seen;
    //          sel we f3     addr   wdata          rdata         flt spl
    vecs[0]  = '{0, 1, 3'b010, 8'h03, 32'h11223344, 32'h00000000, 0, 1};
    vecs[1]  = '{0, 0, 3'b010, 8'h03, 32'h0,        32'h11223344, 0, 1};
    vecs[2]  = '{0, 0, 3'b010, 8'h00, 32'h0,        32'h44020100, 0, 0};
    vecs[3]  = '{0, 1, 3'b010, 8'h00, 32'h8000FF80, 32'h00000000, 0, 0};
    vecs[4]  = '{0, 0, 3'b000, 8'h00, 32'h0,        32'hFFFFFF80, 0, 0};
    vecs[5]  = '{0, 0, 3'b100, 8'h00, 32'h0,        32'h00000080, 0, 0};
    vecs[6]  = '{0, 0, 3'b001, 8'h02, 32'h0,        32'hFFFF8000, 0, 0};
    vecs[7]  = '{0, 0, 3'b101, 8'h02, 32'h0,        32'h00008000, 0, 0};
    vecs[8]  = '{0, 0, 3'b001, 8'h01, 32'h0,        32'h000000FF, 0, 0};
    vecs[9]  = '{0, 0, 3'b000, 8'h01, 32'h0,        32'hFFFFFFFF, 0, 0};
    vecs[10] = '{0, 0, 3'b100, 8'h03, 32'h0,        32'h00000080, 0, 0};
    vecs[11] = '{0, 0, 3'b011, 8'h00, 32'h0,        32'h8000FF80, 0, 0};
    vecs[12] = '{0, 0, 3'b001, 8'h03, 32'h0,        32'h00003380, 0, 1};
    vecs[13] = '{0, 0, 3'b010, 8'h40, 32'h0,        32'h00000000, 1, 0};
    vecs[14] = '{0, 0, 3'b010, 8'h41, 32'h0,        32'h00000000, 1, 0};
    vecs[15] = '{0, 1, 3'b010, 8'h40, 32'hCAFEF00D, 32'h00000000, 1, 0};
    vecs[16] = '{1, 0, 3'b001, 8'h03, 32'h0,        32'h00000000, 1, 0};
    vecs[17] = '{1, 1, 3'b010, 8'h01, 32'hDEADBEEF, 32'h00000000, 1, 0};
    vecs[18] = '{1, 0, 3'b010, 8'h00, 32'h0,        32'h03020100, 0, 0};
    vecs[19] = '{1, 0, 3'b010, 8'h04, 32'h0,        32'h07060504, 0, 0};
    vecs[20] = '{1, 0, 3'b010, 8'h44, 32'h0,        32'h00000000, 1, 0};
    vecs[21] = '{1, 0, 3'b000, 8'h03, 32'h0,        32'h00000003, 0, 0};
    vecs[22] = '{1, 1, 3'b000, 8'h02, 32'h0000005A, 32'h00000000, 0, 0};
    vecs[23] = '{1, 0, 3'b010, 8'h00, 32'h0,        32'h035A0100, 0, 0};
    vecs[24] = '{0, 1, 3'b111, 8'h08, 32'h01234567, 32'h00000000, 0, 0};
    vecs[25] = '{0, 0, 3'b010, 8'h08, 32'h0,        32'h01234567, 0, 0};

    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; dbg_en = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(bus_s.req_ready), 32'd1);
    chk("rst_s_valid", 32'(bus_s.rsp_valid), 32'd0);
    chk("rst_s_rdata", bus_s.rsp_rdata, 32'd0);
    chk("rst_s_fault", 32'(bus_s.rsp_fault), 32'd0);
    chk("rst_f_ready", 32'(bus_f.req_ready), 32'd1);
    chk("rst_f_valid", 32'(bus_f.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Debug init of words 0..7 with a request pending: debug must win.
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h04;
    dbg_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dbg_addr  = 6'(2 * k);
      dbg_wdata = {init_word(2 * k + 1), init_word(2 * k)};
      #1;
      chk($sformatf("dbg%0d_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("dbg%0d_valid", k), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    dbg_en = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("init_lw4_valid", 32'(rsp_valid), 32'd1);
    chk("init_lw4_rdata", rsp_rdata, 32'h07060504);
    chk("init_lw4_fault", 32'(rsp_fault), 32'd0);
    @(negedge clk);

    // Back-to-back SB, SH, LW on word 1: rsp_valid held high every cycle.
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 8'h05; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1;
    chk("b2b_sb_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_sb_rdata", rsp_rdata, 32'd0);
    req_funct3 = 3'b001; req_addr = 8'h06; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    chk("b2b_sh_valid", 32'(rsp_valid), 32'd1);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h04;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b_lw_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_lw_rdata", rsp_rdata, 32'hBEEFAA04);
    chk("b2b_lw_fault", 32'(rsp_fault), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rdata", rsp_rdata, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].sel, vecs[i].we, vecs[i].f3, vecs[i].addr,
             vecs[i].wd, vecs[i].rd, vecs[i].flt, vecs[i].spl);
    end

    // Reset during SPLIT aborts the access with no response.
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h01;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rsplit_ready_n1", 32'(req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rsplit_ready", 32'(req_ready), 32'd1);
    chk("rsplit_valid", 32'(rsp_valid), 32'd0);
    chk("rsplit_rdata", rsp_rdata, 32'd0);
    chk("rsplit_fault", 32'(rsp_fault), 32'd0);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("rsplit_no_rsp", 32'(seen), 32'd0);
    @(negedge clk);
    do_req("post_rst_lw4", 1'b0, 1'b0, 3'b010, 8'h04, 32'h0, 32'hBE112233, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
